sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the CPU's SRAM-like memory bus (req / addr_ok / data_ok handshake).
- Generalises the fixed inst/data split at the CPU top to any master count.
- Supports in-order multiple outstanding transactions and fixed-priority or round-robin arbitration.
- Sits between the core's fetch/LSU ports (plus optional debug/DMA masters) and the shared memory bridge.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
OUTSTANDING, 4, max accepted-but-unanswered transactions; power of 2, >=2
ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
m_req  in  N_MASTERS  per-master request
m_wr  in  N_MASTERS  per-master write flag
m_size  in  2*N_MASTERS  per-master size (0 = byte, 1 = half, 2 = word)
m_addr  in  ADDR_W*N_MASTERS  per-master address, master i at slice i
m_wdata  in  DATA_W*N_MASTERS  per-master write data
m_addr_ok  out  N_MASTERS  request accepted
m_data_ok  out  N_MASTERS  response valid
m_rdata  out  DATA_W  read data, broadcast to all masters
s_req  out  1  slave request
s_wr  out  1  slave write flag
s_size  out  2  slave size
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_addr_ok  in  1  slave accepted request
s_data_ok  in  1  slave response valid
s_rdata  in  DATA_W  slave read data

Behaviour:
- Reset (resetn low, async): lock cleared, rr pointer = 0, ID FIFO empty, count = 0.
- During reset, s_req, m_addr_ok and m_data_ok are 0. s_wr, s_size, s_addr and s_wdata are 0.
- Grant selection:
  - Combinational, one-hot grant over m_req.
  - Fixed mode: lowest requesting index wins.
  - Round-robin mode: the first requester at or after rr_ptr wins, wrapping modulo N_MASTERS.
- Lock:
  - When s_req=1 and s_addr_ok=0, register the granted index and set lock.
  - While locked, grant stays on that master regardless of other requests; masters must hold req and payload stable.
  - Lock clears on the cycle s_addr_ok=1.
- Request path: zero latency. s_req = granted m_req AND NOT fifo_full. s_wr, s_size, s_addr and s_wdata are muxed from the granted master (0 if none granted).
- Acceptance:
  - m_addr_ok[i] = s_addr_ok & s_req & grant[i].
  - On acceptance, push the granted index into the ID FIFO.
  - In round-robin mode, rr_ptr <= (granted+1) mod N_MASTERS.
- Response: the ID FIFO is in-order, depth OUTSTANDING, ID width max(1, clog2(N_MASTERS)). m_data_ok[i] = s_data_ok & !fifo_empty & (head==i). Pop on s_data_ok & !fifo_empty. m_rdata = s_rdata.
- Boundary conditions:
  - FIFO full: s_req forced 0, m_addr_ok all 0, lock retained.
  - Simultaneous push and pop (not full): count unchanged, pointers both advance, wrap modulo OUTSTANDING.
  - Push and pop in the same cycle when count==OUTSTANDING-1: count remains OUTSTANDING-1.
  - s_data_ok with FIFO empty: protocol error; ignored, no m_data_ok, no state change.
  - Same-cycle addr_ok and data_ok for an empty FIFO: the new transaction is not answered that cycle; the slave must answer later.
  - No requesters: grant all-0, s_req=0, rr_ptr unchanged.
  - Reset mid-transaction: FIFO and lock discarded immediately; in-flight responses after reset are ignored.

Test Plan:
1. N=2, fixed mode, both masters request, slave addr_ok every cycle → master 0 accepted every cycle, master 1 never accepted while m_req[0]=1; then drop m_req[0] → master 1 accepted next edge.
2. N=3, round-robin mode, all request continuously, addr_ok=1 → acceptance order 0,1,2,0,1,2; FIFO contents 0,1,2; data_ok delivered to 0,1,2 in order with m_rdata=s_rdata.
3. Master 1 requests with addr 0x1FC0_0010; slave holds addr_ok=0 for 3 cycles while master 0 asserts req → grant stays on master 1 and s_addr stays 0x1FC0_0010; m_addr_ok[1] fires on cycle 4.
4. OUTSTANDING=4, 4 accepts with no data_ok → s_req=0 on the 5th request. One data_ok → s_req reasserts the same cycle the FIFO is no longer full (next cycle after the pop). A simultaneous push/pop at count 3 leaves count at 3.
5. s_data_ok pulsed with FIFO empty → no m_data_ok, pointers unchanged.
6. Assert resetn=0 asynchronously mid-cycle with 2 outstanding → all m_addr_ok/m_data_ok/s_req drop immediately. After release, FIFO is empty and rr_ptr=0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: N-master to 1-slave arbiter for an SRAM-like req/addr_ok/data_ok bus
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_addr/m_wdata   per-master request payload, master i at slice i
//   m_addr_ok/m_data_ok/m_rdata        per-master accept and response strobes, read data broadcast
//   s_req/s_wr/s_size/s_addr/s_wdata   request forwarded to the slave
//   s_addr_ok/s_data_ok/s_rdata        slave accept, response and read data
module sram_like_arbiter #(
  parameter int N_MASTERS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int ARB_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_wr,
  input  logic [2*N_MASTERS-1:0]        m_size,
  input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
  input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_addr_ok,
  output logic [N_MASTERS-1:0]          m_data_ok,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_wr,
  output logic [1:0]                    s_size,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [DATA_W-1:0]             s_rdata
);
  localparam int ID_W  = N_MASTERS > 2 ? $clog2(N_MASTERS) : 1;
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  logic                 lock;
  logic [ID_W-1:0]      lock_idx, rr_ptr, gnt_idx, head;
  logic [ID_W:0]        idx;
  logic                 gnt_vld, full, empty, accept, pop;
  logic [N_MASTERS-1:0] grant;
  logic [ID_W-1:0]      fifo [OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  // A held (locked) request keeps its grant; otherwise search from rr_ptr (0 in fixed mode).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx;
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
        idx = (ARB_MODE != 0 ? {1'b0, rr_ptr} : '0) + (ID_W+1)'(k);
        if (idx >= (ID_W+1)'(N_MASTERS)) idx = idx - (ID_W+1)'(N_MASTERS);
        if (!gnt_vld && m_req[idx[ID_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx[ID_W-1:0];
        end
      end
    end
    if (!resetn) gnt_vld = 1'b0;
  end
  assign full      = count == CNT_W'(OUTSTANDING);
  assign empty     = count == '0;
  assign grant     = gnt_vld ? N_MASTERS'(1) << gnt_idx : '0;
  assign s_req     = gnt_vld & m_req[gnt_idx] & ~full;
  assign accept    = s_req & s_addr_ok;
  assign m_addr_ok = accept ? grant : '0;
  assign head      = fifo[rd_ptr];
  // Responses with nothing outstanding are protocol errors and are dropped.
  assign pop       = resetn & s_data_ok & ~empty;
  assign m_data_ok = pop ? N_MASTERS'(1) << head : '0;
  assign m_rdata   = s_rdata;
  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_addr  = m_addr[ADDR_W*i +: ADDR_W];
        s_wdata = m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk) if (accept) fifo[wr_ptr] <= gnt_idx;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock     <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (s_req && !s_addr_ok) begin
        lock     <= 1'b1;
        lock_idx <= gnt_idx;
      end else if (accept) lock <= 1'b0;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(accept) - CNT_W'(pop);
      if (ARB_MODE != 0 && accept)
        rr_ptr <= gnt_idx == ID_W'(N_MASTERS-1) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed checks of a fixed-priority 2-master and a round-robin 3-master arbiter
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0]  f_req = '0, f_wr = '0, f_aok, f_dok;
  logic [3:0]  f_size = '0;
  logic [63:0] f_addr = '0, f_wdata = '0;
  logic [31:0] f_rdata, f_saddr, f_swdata, f_srdata = '0;
  logic        f_sreq, f_swr, f_saok = 1'b0, f_sdok = 1'b0;
  logic [1:0]  f_ssize;
  logic [2:0]  r_req = '0, r_wr = '0, r_aok, r_dok;
  logic [5:0]  r_size = '0;
  logic [95:0] r_addr = '0, r_wdata = '0;
  logic [31:0] r_rdata, r_saddr, r_swdata, r_srdata = '0;
  logic        r_sreq, r_swr, r_saok = 1'b0, r_sdok = 1'b0;
  logic [1:0]  r_ssize;
  sram_like_arbiter #(.N_MASTERS(2), .OUTSTANDING(4), .ARB_MODE(0)) u_fix (
    .clk(clk), .resetn(resetn), .m_req(f_req), .m_wr(f_wr), .m_size(f_size),
    .m_addr(f_addr), .m_wdata(f_wdata), .m_addr_ok(f_aok), .m_data_ok(f_dok),
    .m_rdata(f_rdata), .s_req(f_sreq), .s_wr(f_swr), .s_size(f_ssize),
    .s_addr(f_saddr), .s_wdata(f_swdata), .s_addr_ok(f_saok), .s_data_ok(f_sdok),
    .s_rdata(f_srdata));
  sram_like_arbiter #(.N_MASTERS(3), .OUTSTANDING(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .resetn(resetn), .m_req(r_req), .m_wr(r_wr), .m_size(r_size),
    .m_addr(r_addr), .m_wdata(r_wdata), .m_addr_ok(r_aok), .m_data_ok(r_dok),
    .m_rdata(r_rdata), .s_req(r_sreq), .s_wr(r_swr), .s_size(r_ssize),
    .s_addr(r_saddr), .s_wdata(r_swdata), .s_addr_ok(r_saok), .s_data_ok(r_sdok),
    .s_rdata(r_srdata));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset: outputs forced low even with live requests and slave strobes
    tick;
    f_req = 2'b11; r_req = 3'b111; f_saok = 1; f_sdok = 1; r_saok = 1; r_sdok = 1;
    f_addr = {32'h2000_0000, 32'h1000_0000};
    r_addr = {32'h0000_00A8, 32'h1FC0_0010, 32'h0000_00A0};
    #1;
    chk("rst_f_sreq", f_sreq, 0);
    chk("rst_f_aok", f_aok, 0);
    chk("rst_f_dok", f_dok, 0);
    chk("rst_f_saddr", f_saddr, 0);
    chk("rst_r_sreq", r_sreq, 0);
    chk("rst_r_aok", r_aok, 0);
    chk("rst_r_dok", r_dok, 0);
    chk("rst_r_saddr", r_saddr, 0);
    tick;
    resetn = 1'b1;
    f_req = '0; r_req = '0; f_saok = 0; f_sdok = 0; r_saok = 0; r_sdok = 0;
    #1;
    chk("idle_r_sreq", r_sreq, 0);
    chk("idle_r_saddr", r_saddr, 0);
    // fixed priority: master 0 always wins, FIFO drained every cycle
    tick;
    f_req = 2'b11; f_saok = 1; f_sdok = 1; f_srdata = 32'h1234_5678;
    #1;
    chk("fix_c0_aok", f_aok, 2'b01);
    chk("fix_c0_dok_empty", f_dok, 2'b00);
    chk("fix_c0_saddr", f_saddr, 32'h1000_0000);
    for (int c = 1; c < 3; c++) begin
      tick;
      chk("fix_aok", f_aok, 2'b01);
      chk("fix_dok", f_dok, 2'b01);
      chk("fix_rdata", f_rdata, 32'h1234_5678);
    end
    tick;
    f_req = 2'b10;
    #1;
    chk("fix_m1_aok", f_aok, 2'b10);
    chk("fix_m1_saddr", f_saddr, 32'h2000_0000);
    chk("fix_m1_dok", f_dok, 2'b01);
    tick;
    f_req = 2'b00; f_saok = 0;
    #1;
    chk("fix_m1_resp", f_dok, 2'b10);
    chk("fix_idle_sreq", f_sreq, 0);
    tick;
    chk("fix_dok_empty", f_dok, 2'b00);
    f_sdok = 0;
    // round robin: 0,1,2 accepted, then accept+respond 0,1,2, then drain 0,1,2
    tick;
    r_req = 3'b111; r_saok = 1; r_srdata = 32'hCAFE_0000;
    #1;
    chk("rr_a0", r_aok, 3'b001);
    chk("rr_a0_saddr", r_saddr, 32'h0000_00A0);
    tick;
    chk("rr_a1", r_aok, 3'b010);
    chk("rr_a1_saddr", r_saddr, 32'h1FC0_0010);
    tick;
    chk("rr_a2", r_aok, 3'b100);
    chk("rr_a2_saddr", r_saddr, 32'h0000_00A8);
    tick;
    r_sdok = 1;
    #1;
    chk("rr_b0_aok", r_aok, 3'b001);
    chk("rr_b0_dok", r_dok, 3'b001);
    chk("rr_b0_rdata", r_rdata, 32'hCAFE_0000);
    tick;
    chk("rr_b1_aok", r_aok, 3'b010);
    chk("rr_b1_dok", r_dok, 3'b010);
    tick;
    chk("rr_b2_aok", r_aok, 3'b100);
    chk("rr_b2_dok", r_dok, 3'b100);
    tick;
    r_req = 3'b000; r_saok = 0;
    #1;
    chk("rr_d0", r_dok, 3'b001);
    tick;
    chk("rr_d1", r_dok, 3'b010);
    tick;
    chk("rr_d2", r_dok, 3'b100);
    tick;
    r_sdok = 0;
    // lock: master 1 stalled three cycles while master 0 (next in rr order) also requests
    r_req = 3'b010; r_wr = 3'b010; r_size = 6'b00_10_00; r_wdata = {32'h0, 32'hDEAD_BEEF, 32'h0};
    #1;
    chk("lock_c1_saddr", r_saddr, 32'h1FC0_0010);
    chk("lock_c1_swr", r_swr, 1);
    chk("lock_c1_ssize", r_ssize, 2);
    chk("lock_c1_swdata", r_swdata, 32'hDEAD_BEEF);
    chk("lock_c1_aok", r_aok, 0);
    tick;
    r_req = 3'b011;
    #1;
    chk("lock_c2_saddr", r_saddr, 32'h1FC0_0010);
    chk("lock_c2_aok", r_aok, 0);
    tick;
    chk("lock_c3_saddr", r_saddr, 32'h1FC0_0010);
    chk("lock_c3_sreq", r_sreq, 1);
    tick;
    r_saok = 1;
    #1;
    chk("lock_c4_aok", r_aok, 3'b010);
    tick;
    r_req = 0; r_wr = 0; r_size = 0; r_wdata = 0; r_saok = 0; r_sdok = 1;
    #1;
    chk("lock_resp", r_dok, 3'b010);
    // FIFO full: accepts 2,0,1,2 then s_req blocked
    tick;
    r_sdok = 0; r_req = 3'b111; r_saok = 1;
    #1;
    chk("full_a0", r_aok, 3'b100);
    tick;
    chk("full_a1", r_aok, 3'b001);
    tick;
    chk("full_a2", r_aok, 3'b010);
    tick;
    chk("full_a3", r_aok, 3'b100);
    tick;
    chk("full_sreq", r_sreq, 0);
    chk("full_aok", r_aok, 0);
    tick;
    r_sdok = 1;
    #1;
    chk("full_pop_sreq", r_sreq, 0);
    chk("full_pop_dok", r_dok, 3'b100);
    tick;
    chk("pp3_sreq", r_sreq, 1);
    chk("pp3_aok", r_aok, 3'b001);
    chk("pp3_dok", r_dok, 3'b001);
    tick;
    r_sdok = 0;
    #1;
    chk("pp3_after_sreq", r_sreq, 1);
    chk("pp3_after_aok", r_aok, 3'b010);
    tick;
    chk("refull_sreq", r_sreq, 0);
    r_req = 0; r_saok = 0; r_sdok = 1;
    #1;
    chk("drain0", r_dok, 3'b010);
    tick;
    chk("drain1", r_dok, 3'b100);
    tick;
    chk("drain2", r_dok, 3'b001);
    tick;
    chk("drain3", r_dok, 3'b010);
    tick;
    chk("empty_dok", r_dok, 3'b000);
    // reset with two outstanding (accept 2 then 0)
    tick;
    r_sdok = 0; r_req = 3'b111; r_saok = 1;
    #1;
    chk("pre_rst_a0", r_aok, 3'b100);
    tick;
    chk("pre_rst_a1", r_aok, 3'b001);
    tick;
    r_sdok = 1;
    #1;
    chk("pre_rst_sreq", r_sreq, 1);
    chk("pre_rst_dok", r_dok, 3'b100);
    resetn = 1'b0;
    #1;
    chk("mid_rst_sreq", r_sreq, 0);
    chk("mid_rst_aok", r_aok, 0);
    chk("mid_rst_dok", r_dok, 0);
    tick;
    resetn = 1'b1;
    #1;
    chk("post_rst_aok", r_aok, 3'b001);
    chk("post_rst_dok", r_dok, 3'b000);
    tick;
    r_req = 0; r_saok = 0;
    #1;
    chk("post_rst_resp", r_dok, 3'b001);
    tick;
    r_sdok = 0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
